seq_divider_4by2: RTL and testbench

- Sequential restoring divider; the inverse of the team's gate-level 2x2 multiplier.
- Takes a DVD_W-bit dividend (product-width operand) and a DVS_W-bit divisor; returns quotient and remainder.
- Produces one quotient bit per clock.
- Sits beside the multiplier in the FPGA datapath so products can be decomposed and checked.

---
 rtl/seq_divider_4by2_pkg.sv | 21 ++
 rtl/seq_divider_4by2_div_step.sv | 24 ++
 rtl/seq_divider_4by2.sv | 138 +++++++++++++
 tb/tb_seq_divider_4by2.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_4by2_pkg.sv
// Shared state encoding and width defaults for the sequential restoring divider.
// Latency: n/a (declarations only). Backpressure: n/a.
// Counter width helper guards the DVD_W=1 corner where $clog2 would give 0.
package seq_divider_4by2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DVD_W = 4;
  localparam int DEF_DVS_W = 2;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_w(DEF_DVD_W);

endpackage

// File: rtl/seq_divider_4by2_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
// Latency: purely combinational. Backpressure: none.
// Remainder in is always < divisor, so the restored result fits back in DVS_W bits.
module seq_divider_4by2_div_step
  import seq_divider_4by2_pkg::*;
#(
  parameter int DVS_W = DEF_DVS_W
) (
  input  logic [DVS_W-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] rem_out,
  output logic             q_bit
);

  logic [DVS_W:0] r_ext;
  logic [DVS_W:0] dvs_ext;

  assign r_ext   = {rem_in, dvd_bit};
  assign dvs_ext = {1'b0, divisor};
  assign q_bit   = (r_ext >= dvs_ext);
  assign rem_out = DVS_W'(q_bit ? (r_ext - dvs_ext) : r_ext);

endmodule

// File: rtl/seq_divider_4by2.sv
// Sequential unsigned restoring divider, one quotient bit per clock (SEQ_DIVIDER_SELFCHECK_EN adds chk_err).
// Latency: DVD_W edges after the accepting edge (1 edge for divide-by-zero). Backpressure: start taken only while ready.
// Results hold until the next accepted start completes; rst clears everything synchronously.
module seq_divider_4by2
  import seq_divider_4by2_pkg::*;
#(
  parameter int DVD_W = DEF_DVD_W,
  parameter int DVS_W = DEF_DVS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_zero
`ifdef SEQ_DIVIDER_SELFCHECK_EN
 ,output logic             chk_err
`endif
);

  localparam int CNT_W = cnt_w(DVD_W);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] dvd_sh;
  logic [DVD_W-1:0] quo_sh;
  logic [DVS_W-1:0] rem_r;
  logic [DVS_W-1:0] dvs_r;
  logic [DVS_W-1:0] step_rem;
  logic             step_q;
  logic [DVD_W-1:0] quo_nxt;
  logic             accept;
  logic             run_last;

  seq_divider_4by2_div_step #(.DVS_W(DVS_W)) u_step (
    .rem_in  (rem_r),
    .dvd_bit (dvd_sh[DVD_W-1]),
    .divisor (dvs_r),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign quo_nxt  = DVD_W'({quo_sh, step_q});
  assign run_last = (state == RUN) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        // A start in the done cycle relaunches without passing through IDLE.
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = ready && start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      dvd_sh    <= '0;
      quo_sh    <= '0;
      rem_r     <= '0;
      dvs_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      cnt    <= CNT_W'(DVD_W - 1);
      dvd_sh <= dividend;
      quo_sh <= '0;
      rem_r  <= '0;
      dvs_r  <= divisor;
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= '0;
        div_zero  <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt    <= cnt - 1'b1;
      dvd_sh <= dvd_sh << 1;
      quo_sh <= quo_nxt;
      rem_r  <= step_rem;
      if (run_last) begin
        quotient  <= quo_nxt;
        remainder <= step_rem;
        div_zero  <= 1'b0;
      end
    end
  end

`ifdef SEQ_DIVIDER_SELFCHECK_EN
  localparam int RW = DVD_W + DVS_W + 1;

  logic [DVD_W-1:0] dvd_cap;
  logic [RW-1:0]    recon;

  // Rebuild the dividend from the final step's results so a fault shows on the same edge.
  assign recon = RW'(quo_nxt) * RW'(dvs_r) + RW'(step_rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_cap <= '0;
      chk_err <= 1'b0;
    end else if (accept) begin
      dvd_cap <= dividend;
      if (divisor == '0) chk_err <= 1'b0;
    end else if (run_last) begin
      chk_err <= (recon != RW'(dvd_cap));
    end
  end
`endif

endmodule

// File: tb/tb_seq_divider_4by2.sv
// Randomized and directed bench for seq_divider_4by2 against an arithmetic reference model.
module tb_seq_divider_4by2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [1:0] divisor;
  logic       ready, busy, done;
  logic [3:0] quotient;
  logic [1:0] remainder;
  logic       div_zero;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
  logic       chk_err;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_divider_4by2 #(.DVD_W(4), .DVS_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
`ifdef SEQ_DIVIDER_SELFCHECK_EN
   ,.chk_err   (chk_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {quotient, remainder, div_zero} from plain unsigned arithmetic.
  function automatic logic [6:0] ref_div(input int a, input int b);
    if (b == 0) return {4'hF, 2'd0, 1'b1};
    return {4'(a / b), 2'(a % b), 1'b0};
  endfunction

  // Edges counted from the edge after which start is raised; 99 means done never came.
  task automatic run_op(input int a, input int b, output int edges, output int busy_cycles);
    dividend = 4'(a);
    divisor  = 2'(b);
    start    = 1'b1;
    tick();
    start       = 1'b0;
    edges       = 1;
    busy_cycles = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      tick();
      edges++;
    end
    if (!done) edges = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 4'd0; divisor = 2'd0;
    tick(); tick();
    checks++;
    if ({ready, busy, done, quotient, remainder, div_zero} !== {3'b100, 7'd0})
      $display("FAIL reset: got %b expected %b", {ready, busy, done, quotient, remainder, div_zero}, {3'b100, 7'd0});
    else passed++;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
    checks++;
    if (chk_err !== 1'b0) $display("FAIL reset_chk_err: got %b expected 0", chk_err);
    else passed++;
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int e, b;
    run_op(9, 2, e, b);
    checks++;
    if (e !== 5) $display("FAIL basic_latency: got %0d expected 5", e); else passed++;
    checks++;
    if (b !== 4) $display("FAIL basic_busy: got %0d expected 4", b); else passed++;
    checks++;
    if ({quotient, remainder, div_zero} !== ref_div(9, 2))
      $display("FAIL basic_result: got %h expected %h", {quotient, remainder, div_zero}, ref_div(9, 2));
    else passed++;
    tick(); tick();
    checks++;
    if ({done, ready, quotient, remainder, div_zero} !== {2'b01, ref_div(9, 2)})
      $display("FAIL idle_hold: got %h expected %h", {done, ready, quotient, remainder, div_zero}, {2'b01, ref_div(9, 2)});
    else passed++;
  endtask

  task automatic test_pairs();
    int e, b;
    int ops[2][2] = '{'{15, 3}, '{0, 1}};
    for (int i = 0; i < 2; i++) begin
      run_op(ops[i][0], ops[i][1], e, b);
      checks++;
      if ({quotient, remainder, div_zero} !== ref_div(ops[i][0], ops[i][1]))
        $display("FAIL pair_%0d: got %h expected %h", i, {quotient, remainder, div_zero}, ref_div(ops[i][0], ops[i][1]));
      else passed++;
    end
  endtask

  task automatic test_div_zero();
    int e, b;
    run_op(6, 0, e, b);
    checks++;
    if (e !== 1) $display("FAIL div_zero_latency: got %0d expected 1", e); else passed++;
    checks++;
    if ({quotient, remainder, div_zero} !== {4'hF, 2'd0, 1'b1})
      $display("FAIL div_zero_result: got %h expected %h", {quotient, remainder, div_zero}, {4'hF, 2'd0, 1'b1});
    else passed++;
    tick();
  endtask

  task automatic test_start_ignored();
    int e;
    dividend = 4'd9; divisor = 2'd2; start = 1'b1;
    tick();
    dividend = 4'd15; divisor = 2'd1;
    tick();
    start = 1'b0;
    e = 2;
    while (!done && e < 20) begin tick(); e++; end
    checks++;
    if (e !== 5) $display("FAIL ignored_latency: got %0d expected 5", e); else passed++;
    checks++;
    if ({quotient, remainder, div_zero} !== ref_div(9, 2))
      $display("FAIL ignored_result: got %h expected %h", {quotient, remainder, div_zero}, ref_div(9, 2));
    else passed++;
    // Relaunch straight from the done cycle; old results must hold during the run.
    dividend = 4'd15; divisor = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({done, busy, quotient, remainder} !== {2'b01, 4'd4, 2'd1})
      $display("FAIL relaunch_hold: got %h expected %h", {done, busy, quotient, remainder}, {2'b01, 4'd4, 2'd1});
    else passed++;
    e = 1;
    while (!done && e < 20) begin tick(); e++; end
    checks++;
    if ({e[3:0], quotient, remainder, div_zero} !== {4'd5, ref_div(15, 1)})
      $display("FAIL relaunch_result: got %h expected %h", {e[3:0], quotient, remainder, div_zero}, {4'd5, ref_div(15, 1)});
    else passed++;
  endtask

  task automatic test_rst_mid_run();
    int e, b, seen;
    dividend = 4'd13; divisor = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ready, busy, done, quotient, remainder, div_zero} !== {3'b100, 7'd0})
      $display("FAIL rst_mid_run: got %b expected %b", {ready, busy, done, quotient, remainder, div_zero}, {3'b100, 7'd0});
    else passed++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) $display("FAIL rst_no_done: got %0d done cycles expected 0", seen); else passed++;
    run_op(13, 3, e, b);
    checks++;
    if ({quotient, remainder, div_zero} !== ref_div(13, 3))
      $display("FAIL rst_fresh: got %h expected %h", {quotient, remainder, div_zero}, ref_div(13, 3));
    else passed++;
  endtask

  task automatic test_sweep();
    int e, b;
    for (int a = 0; a < 16; a++) begin
      for (int d = 0; d < 4; d++) begin
        run_op(a, d, e, b);
        checks++;
        if ({quotient, remainder, div_zero} !== ref_div(a, d))
          $display("FAIL sweep_%0d_%0d: got %h expected %h", a, d, {quotient, remainder, div_zero}, ref_div(a, d));
        else passed++;
        checks++;
        if (e !== ((d == 0) ? 1 : 5))
          $display("FAIL sweep_lat_%0d_%0d: got %0d expected %0d", a, d, e, (d == 0) ? 1 : 5);
        else passed++;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
        checks++;
        if (chk_err !== 1'b0) $display("FAIL sweep_chk_%0d_%0d: got %b expected 0", a, d, chk_err);
        else passed++;
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    int e, b, a, d;
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(15, 0));
      d = int'($urandom_range(3, 0));
      run_op(a, d, e, b);
      checks++;
      if ({quotient, remainder, div_zero} !== ref_div(a, d))
        $display("FAIL random_%0d (%0d/%0d): got %h expected %h", i, a, d, {quotient, remainder, div_zero}, ref_div(a, d));
      else passed++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_pairs();
    test_div_zero();
    test_start_ignored();
    test_rst_mid_run();
    test_sweep();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
